// File: rtl/note_sequencer_pkg.sv
// Shared sound definitions: duration codes, note word layout and sequencer states.
package note_sequencer_pkg;

    localparam logic [2:0] DUR_END       = 3'd0;
    localparam logic [2:0] DUR_QUARTER   = 3'd1;
    localparam logic [2:0] DUR_EIGHTH    = 3'd2;
    localparam logic [2:0] DUR_THIRD     = 3'd3;
    localparam logic [2:0] DUR_SIXTEENTH = 3'd4;
    localparam logic [2:0] DUR_SIXTH     = 3'd5;

    localparam int PITCH_MSB = 7;
    localparam int PITCH_LSB = 3;
    localparam int DUR_MSB   = 2;
    localparam int DUR_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_PLAY  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    // Codes 6 and 7 are reserved and never presented to the duration FSM.
    function automatic logic is_playable(input logic [2:0] code);
        return (code != DUR_END) && (code <= DUR_SIXTH);
    endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Song ROM read port plus the note hand-off to the duration state machine.
interface note_sequencer_if #(parameter int ADDR_W = 6);
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [4:0]        pitch;
    logic [2:0]        duration;
    logic              next_note;

    modport master (output rom_addr, pitch, duration, input rom_data, next_note);
    modport slave  (input rom_addr, pitch, duration, output rom_data, next_note);
endinterface

// File: rtl/note_prefetch.sv
// Single-entry note holding slot; load wins over drain, flush wins over both.
module note_prefetch
    import note_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       clr_n,
    input  logic       load_i,
    input  logic       drain_i,
    input  logic       flush_i,
    input  logic [7:0] data_i,
    output logic       vld_o,
    output logic [7:0] data_o
);

    logic       vld_q, vld_d;
    logic [7:0] data_q, data_d;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (flush_i) begin
            vld_d = 1'b0;
        end else if (load_i) begin
            vld_d  = 1'b1;
            data_d = data_i;
        end else if (drain_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;

endmodule

// File: rtl/note_sequencer.sv
// Song playback front end: walks the song ROM, decodes note words and feeds the
// duration FSM with a one-word prefetch so the next duration is ready on request.
module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    output logic              playing,
    output logic              song_done,
    note_sequencer_if.master  bus
);

    seq_state_e        state_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [4:0]        pitch_q;
    logic [2:0]        dur_q;
    logic              rd1_q, rd2_q, eos_q, wrap_q;
    logic              playing_q, song_done_q;

    logic       pf_vld;
    logic [7:0] pf_data;

    logic       active, nn_eff, cap, cap_play, cap_end, out_free;
    logic       cap_direct, pf_load, pf_drain, pf_flush;
    logic       slot_free_nx, eos_d, wrap_req, issue, go_done;
    logic [2:0] cap_code;
    logic [4:0] cap_pitch;

    // A read takes two edges: the ROM latches the address, then the word is captured.
    always_comb begin
        active       = (state_q == ST_PRIME) || (state_q == ST_PLAY);
        nn_eff       = bus.next_note && (state_q == ST_PLAY);
        cap          = rd2_q && active;
        cap_code     = bus.rom_data[DUR_MSB:DUR_LSB];
        cap_pitch    = bus.rom_data[PITCH_MSB:PITCH_LSB];
        cap_play     = cap && is_playable(cap_code);
        cap_end      = cap && (cap_code == DUR_END);
        out_free     = (dur_q == DUR_END) || (nn_eff && !pf_vld);
        cap_direct   = cap_play && out_free;
        pf_load      = cap_play && !out_free;
        pf_drain     = nn_eff && pf_vld;
        go_done      = nn_eff && !pf_vld && eos_q;
        pf_flush     = stop || go_done;
        slot_free_nx = (!pf_vld || pf_drain) && !pf_load;
        eos_d        = eos_q || (cap_end && !loop);
        wrap_req     = wrap_q || (cap_end && loop);
        issue        = active && slot_free_nx && !rd1_q && !eos_d;
    end

    note_prefetch u_prefetch (
        .clk     (clk),
        .clr_n   (clr_n),
        .load_i  (pf_load),
        .drain_i (pf_drain),
        .flush_i (pf_flush),
        .data_i  (bus.rom_data),
        .vld_o   (pf_vld),
        .data_o  (pf_data)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= ST_IDLE;
            rom_addr_q  <= '0;
            pitch_q     <= '0;
            dur_q       <= DUR_END;
            rd1_q       <= 1'b0;
            rd2_q       <= 1'b0;
            eos_q       <= 1'b0;
            wrap_q      <= 1'b0;
            playing_q   <= 1'b0;
            song_done_q <= 1'b0;
        end else begin
            song_done_q <= 1'b0;
            if (stop) begin
                state_q    <= ST_IDLE;
                rom_addr_q <= '0;
                pitch_q    <= '0;
                dur_q      <= DUR_END;
                rd1_q      <= 1'b0;
                rd2_q      <= 1'b0;
                eos_q      <= 1'b0;
                wrap_q     <= 1'b0;
                playing_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            state_q    <= ST_PRIME;
                            rom_addr_q <= '0;
                            rd1_q      <= 1'b1;
                            rd2_q      <= 1'b0;
                            playing_q  <= 1'b1;
                        end
                    end
                    ST_PRIME, ST_PLAY: begin
                        if (go_done) begin
                            state_q     <= ST_DONE;
                            pitch_q     <= '0;
                            dur_q       <= DUR_END;
                            rd1_q       <= 1'b0;
                            rd2_q       <= 1'b0;
                            eos_q       <= 1'b0;
                            wrap_q      <= 1'b0;
                            playing_q   <= 1'b0;
                            song_done_q <= 1'b1;
                        end else begin
                            rd2_q  <= rd1_q;
                            rd1_q  <= issue;
                            eos_q  <= eos_d;
                            wrap_q <= wrap_req && !issue;
                            if (issue)
                                rom_addr_q <= wrap_req ? '0 : rom_addr_q + 1'b1;
                            // Underrun leaves pitch untouched and only parks duration.
                            if (cap_direct) begin
                                pitch_q <= cap_pitch;
                                dur_q   <= cap_code;
                                state_q <= ST_PLAY;
                            end else if (pf_drain) begin
                                pitch_q <= pf_data[PITCH_MSB:PITCH_LSB];
                                dur_q   <= pf_data[DUR_MSB:DUR_LSB];
                            end else if (nn_eff) begin
                                dur_q <= DUR_END;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.pitch    = pitch_q;
    assign bus.duration = dur_q;
    assign playing      = playing_q;
    assign song_done    = song_done_q;

endmodule
